alsu_cmd_issuer: RTL and testbench
==================================

Name: alsu_cmd_issuer

Overview:
Upstream command stage for the ALSU. Accepts packed ALSU commands over a valid/ready handshake and buffers them in a small FIFO. Drives the ALSU input pins, one command per clock, and expands shift/rotate commands into multi-cycle repeats. Optionally filters illegal commands. Emits a result-valid strobe aligned with the ALSU's registered output so a downstream checker can sample `out`/`leds`.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
DROP_INVALID, 1, 1 = discard illegal commands and count them; 0 = forward them unchanged
ALSU_LAT, 2, cycles from issue to ALSU `out` valid (input reg + output reg)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset (see below)
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_data  in  20  alsu_cmd_t {opcode[2:0], A[2:0], B[2:0], cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in, rep[3:0]}
flush  in  1  discard all queued/active commands
issue_valid  out  1  ALSU pins carry a real command this cycle
opcode  out  3  to ALSU
A, B  out  3 each, signed, to ALSU
cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in  out  1 each, to ALSU
res_valid  out  1  ALSU `out`/`leds` reflect an issued command
fifo_count  out  $clog2(DEPTH+1)  entries queued
drop_cnt  out  8  saturating count of dropped illegal commands

Behaviour:
- Reset: one clock; `rst` is synchronous and active-low. While low, all outputs are 0, FIFO is empty, state is IDLE, `drop_cnt` is 0 and the res_valid pipe is cleared. Reset mid-REPEAT abandons the command.
- `cmd_ready` = (fifo_count < DEPTH) && !flush. It is computed from the registered count with no pop bypass, so a full FIFO refuses even in a pop cycle.
- Push occurs on cmd_valid && cmd_ready.
- Illegal command: opcode 6/7, or (red_op_A|red_op_B) with opcode not 0/1.
  - DROP_INVALID=1: the command is handshaken but not written; drop_cnt += 1, saturating at 255.
  - DROP_INVALID=0: the command is written as-is.
- State machine:
  - IDLE: if FIFO is non-empty, pop the head into the output register next cycle, set issue_valid=1, then go to ISSUE.
  - ISSUE: if the issued opcode is 4/5 and rep != 0, load rep_cnt = rep and go to REPEAT. Otherwise pop the next head if available (back-to-back, 1 cmd/cycle), or go to IDLE.
  - REPEAT: hold all pins and issue_valid=1. Decrement rep_cnt; when it reaches 0, behave as ISSUE's pop decision.
  - rep is ignored for opcodes other than 4/5.
- Idle pattern (issue_valid=0): opcode=0 (OR), A=B=0, all 1-bit pins 0. This drives ALSU out toward 0.
- res_valid is issue_valid delayed by ALSU_LAT cycles through a shift register.
- flush:
  - Next cycle: FIFO empty, REPEAT aborted, state IDLE, idle pattern on the pins.
  - In-flight res_valid bits are still delivered.
  - A push in the same cycle is refused, because cmd_ready is low.
- Simultaneous push and pop: fifo_count is unchanged and the FIFO pointers wrap modulo DEPTH.

Decomposition:
- Package `alsu_issue_pkg`:
  - `alsu_cmd_t` packed struct.
  - `opcode_e`-compatible constants (OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5).
  - `is_illegal()` function.
  - `IDLE_CMD` constant.
  - `state_e` {IDLE, ISSUE, REPEAT}.
- One sub-module, `cmd_fifo` (parameterised DEPTH/width, sync active-low reset, push/pop/count/flush).

Test Plan:
1. Reset low for 2 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=0; after release cmd_ready=1 and fifo_count=0.
2. Push 3 legal ADD cmds back-to-back (A=2,B=1,cin=1 etc.) -> issue_valid=1 on 3 consecutive cycles starting 1 cycle after the first push; res_valid high on 3 cycles starting ALSU_LAT later; ALSU out=4 for the first command.
3. Push SHIFT with rep=3, direction=1, serial_in=1 -> pins held for 4 cycles, then the next command or the idle pattern.
4. With DROP_INVALID=1, push opcode=6 then OR with red_op_A=1 -> first command dropped (drop_cnt=1); second command issued. Push opcode=2 with red_op_B=1 -> drop_cnt=2.
5. Stall issue via a long REPEAT (rep=15), push DEPTH+1 cmds -> cmd_ready falls at fifo_count=8; the ninth command is held until a pop, with no loss or duplication.
6. Assert flush mid-REPEAT with 5 queued -> next cycle fifo_count=0, issue_valid=0, idle pattern on pins; already-issued res_valid pulses still appear.

Source files
------------

// File: rtl/alsu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alsu_issue_pkg
// Shared types and helpers for the ALSU command issuer:
//   alsu_cmd_t     : 20-bit packed command as it arrives on cmd_data
//   opcode_e       : ALSU opcode values (OR, XOR, ADD, MULT, SHIFT, ROTATE)
//   state_e        : issuer state machine states
//   IDLE_CMD       : pin pattern driven while nothing is being issued
//   is_illegal     : commands the ALSU cannot execute meaningfully
//   is_multi_cycle : shift/rotate commands that expand into repeats
// ---------------------------------------------------------------------------
package alsu_issue_pkg;

  // Field order matches the bit layout on cmd_data, MSB first.
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] A;
    logic [2:0] B;
    logic       cin;
    logic       red_op_A;
    logic       red_op_B;
    logic       bypass_A;
    logic       bypass_B;
    logic       direction;
    logic       serial_in;
    logic [3:0] rep;
  } alsu_cmd_t;

  localparam int CMD_W = $bits(alsu_cmd_t);

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // OR of zero operands keeps the ALSU output settling toward 0.
  localparam alsu_cmd_t IDLE_CMD = '0;

  // Opcodes 6/7 do not exist, and the reduction modifiers only make sense
  // for the bitwise OR/XOR operations.
  function automatic logic is_illegal(input alsu_cmd_t c);
    logic badOpcode;
    logic badReduction;
    badOpcode    = (c.opcode > OP_ROTATE);
    badReduction = (c.red_op_A || c.red_op_B) &&
                   !((c.opcode == OP_OR) || (c.opcode == OP_XOR));
    return badOpcode || badReduction;
  endfunction

  // Only shift/rotate honour the repeat count; a count of 0 means one shot.
  function automatic logic is_multi_cycle(input alsu_cmd_t c);
    return ((c.opcode == OP_SHIFT) || (c.opcode == OP_ROTATE)) &&
           (c.rep != 4'd0);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO holding queued ALSU commands.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   i_flush      : empty the FIFO on the next edge (overrides push/pop)
//   i_push       : write i_pushData (ignored when full)
//   i_pushData   : entry to write
//   i_pop        : advance the read pointer (ignored when empty)
//   o_headData   : oldest entry, valid whenever o_empty is low
//   o_count      : number of stored entries
//   o_empty      : no entries stored
//   o_full       : DEPTH entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 20,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_count    = r_count;
  assign o_headData = r_mem[r_rdPtr];

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alsu_cmd_issuer
// Front end for the ALSU: queues packed commands, drives the ALSU input pins
// one command per clock, stretches shift/rotate commands over rep extra
// cycles, optionally filters illegal commands, and produces a strobe that
// lines up with the ALSU's registered output.
// Ports:
//   clk, rst          : clock and synchronous active-low reset
//   cmd_valid/ready   : command handshake; cmd_data is an alsu_cmd_t
//   flush             : drop everything queued or being issued
//   issue_valid       : the ALSU pins carry a real command this cycle
//   opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
//   direction, serial_in : registered ALSU input pins
//   res_valid         : issue_valid delayed by ALSU_LAT cycles
//   fifo_count        : queued entries
//   drop_cnt          : saturating count of discarded illegal commands
// ---------------------------------------------------------------------------
module alsu_cmd_issuer
  import alsu_issue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter bit DROP_INVALID = 1'b1,
  parameter int ALSU_LAT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [19:0]                  cmd_data,
  input  logic                         flush,
  output logic                         issue_valid,
  output logic [2:0]                   opcode,
  output logic signed [2:0]            A,
  output logic signed [2:0]            B,
  output logic                         cin,
  output logic                         red_op_A,
  output logic                         red_op_B,
  output logic                         bypass_A,
  output logic                         bypass_B,
  output logic                         direction,
  output logic                         serial_in,
  output logic                         res_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [7:0]                   drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  alsu_cmd_t         w_cmdIn;
  alsu_cmd_t         w_head;
  logic              w_empty;
  logic              w_full;
  logic [CW-1:0]     w_count;
  logic              w_handshake;
  logic              w_illegal;
  logic              w_push;
  logic              w_dropEvt;
  logic              w_startRepeat;
  logic              w_advance;
  logic              w_pop;

  state_e            r_state;
  alsu_cmd_t         r_cmd;
  logic              r_issueValid;
  logic [3:0]        r_repCnt;
  logic [7:0]        r_dropCnt;
  logic [ALSU_LAT-1:0] r_resPipe;

  assign w_cmdIn = alsu_cmd_t'(cmd_data);

  // Ready comes from the registered count only, so a full FIFO refuses even
  // in a cycle where it is about to pop. Held low throughout reset.
  assign cmd_ready   = rst && !w_full && !flush;
  assign w_handshake = cmd_valid && cmd_ready;
  assign w_illegal   = is_illegal(w_cmdIn);

  // Dropped commands are still handshaken so upstream never stalls on them.
  assign w_dropEvt = w_handshake && DROP_INVALID && w_illegal;
  assign w_push    = w_handshake && !w_dropEvt;

  // w_advance marks the cycle the current command (if any) is finished and
  // the next head may be taken; it is shared by IDLE, ISSUE and the last
  // REPEAT cycle so back-to-back issue needs no bubble.
  assign w_startRepeat = (r_state == ISSUE) && is_multi_cycle(r_cmd);
  assign w_advance     = (r_state == IDLE) ||
                         ((r_state == ISSUE) && !w_startRepeat) ||
                         ((r_state == REPEAT) && (r_repCnt == 4'd1));
  assign w_pop         = rst && !flush && w_advance && !w_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_pushData (w_cmdIn),
    .i_pop      (w_pop),
    .o_headData (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Issue state machine. The pins are the r_cmd register itself, so the
  // idle pattern is simply IDLE_CMD loaded whenever nothing is issued.
  // In REPEAT, r_repCnt counts the extra cycles still to hold; the hold ends
  // on the cycle it would reach zero.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_state      <= IDLE;
      r_cmd        <= IDLE_CMD;
      r_issueValid <= 1'b0;
      r_repCnt     <= 4'd0;
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_startRepeat) begin
            r_repCnt <= r_cmd.rep;
            r_state  <= REPEAT;
          end
        end
        REPEAT: begin
          if (!w_advance) begin
            r_repCnt <= r_repCnt - 4'd1;
          end
        end
        default: begin
          r_repCnt <= 4'd0;
        end
      endcase
      if (w_advance) begin
        if (!w_empty) begin
          r_cmd        <= w_head;
          r_issueValid <= 1'b1;
          r_state      <= ISSUE;
        end else begin
          r_cmd        <= IDLE_CMD;
          r_issueValid <= 1'b0;
          r_state      <= IDLE;
        end
      end
    end
  end

  // Saturating drop counter for discarded illegal commands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dropCnt <= 8'd0;
    end else if (w_dropEvt && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  // Delay line matching the ALSU's input and output registers. Flush does
  // not clear it, so results of already-issued commands are still flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resPipe <= '0;
    end else begin
      r_resPipe[0] <= r_issueValid;
      for (int i = 1; i < ALSU_LAT; i++) begin
        r_resPipe[i] <= r_resPipe[i-1];
      end
    end
  end

  assign issue_valid = r_issueValid;
  assign opcode      = r_cmd.opcode;
  assign A           = r_cmd.A;
  assign B           = r_cmd.B;
  assign cin         = r_cmd.cin;
  assign red_op_A    = r_cmd.red_op_A;
  assign red_op_B    = r_cmd.red_op_B;
  assign bypass_A    = r_cmd.bypass_A;
  assign bypass_B    = r_cmd.bypass_B;
  assign direction   = r_cmd.direction;
  assign serial_in   = r_cmd.serial_in;
  assign res_valid   = r_resPipe[ALSU_LAT-1];
  assign fifo_count  = w_count;
  assign drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alsu_cmd_issuer
// Directed scenarios plus a randomized run. A queue-based reference model
// tracks what is queued, which command is on the pins and how many cycles it
// still owns them; a negedge process compares every DUT output against it.
// ---------------------------------------------------------------------------
module tb_alsu_cmd_issuer;

  localparam int DEPTH        = 8;
  localparam bit DROP_INVALID = 1'b1;
  localparam int ALSU_LAT     = 2;
  localparam int CW           = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [19:0]         cmd_data;
  logic                flush;
  logic                issue_valid;
  logic [2:0]          opcode;
  logic signed [2:0]   A;
  logic signed [2:0]   B;
  logic                cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in;
  logic                res_valid;
  logic [CW-1:0]       fifo_count;
  logic [7:0]          drop_cnt;

  always #5 clk = ~clk;

  alsu_cmd_issuer #(
    .DEPTH        (DEPTH),
    .DROP_INVALID (DROP_INVALID),
    .ALSU_LAT     (ALSU_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .flush       (flush),
    .issue_valid (issue_valid),
    .opcode      (opcode),
    .A           (A),
    .B           (B),
    .cin         (cin),
    .red_op_A    (red_op_A),
    .red_op_B    (red_op_B),
    .bypass_A    (bypass_A),
    .bypass_B    (bypass_B),
    .direction   (direction),
    .serial_in   (serial_in),
    .res_valid   (res_valid),
    .fifo_count  (fifo_count),
    .drop_cnt    (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  int maxCount = 0;

  // Reference model state: queued commands, the command on the pins and the
  // number of cycles it still holds them, drop count, and the result delay.
  logic [19:0] mq[$];
  bit          mActive = 1'b0;
  logic [19:0] mCur = '0;
  int          mRemain = 0;
  int          mDrop = 0;
  bit          mResQ[$];
  bit          mRes = 1'b0;

  function automatic logic [19:0] mkCmd(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] flags,
                                        input logic [3:0] rep);
    // flags = {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}
    return {op, a, b, flags, rep};
  endfunction

  function automatic bit refIllegal(input logic [19:0] c);
    int op;
    op = int'(c[19:17]);
    if (op >= 6) return 1'b1;
    if ((c[9] || c[8]) && op > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int holdCycles(input logic [19:0] c);
    int op;
    op = int'(c[19:17]);
    if (op == 4 || op == 5) return 1 + int'(c[3:0]);
    return 1;
  endfunction

  // Model update on every rising edge using the inputs that edge samples.
  always @(posedge clk) begin : refModel
    bit wasActive;
    bit couldAccept;
    if (rst !== 1'b1) begin
      mq.delete();
      mActive = 1'b0;
      mCur    = '0;
      mRemain = 0;
      mDrop   = 0;
      mRes    = 1'b0;
      mResQ.delete();
      for (int i = 0; i < ALSU_LAT - 1; i++) mResQ.push_back(1'b0);
    end else begin
      wasActive   = mActive;
      couldAccept = (mq.size() < DEPTH) && !flush;
      mResQ.push_back(wasActive);
      mRes = mResQ.pop_front();
      if (flush) begin
        mq.delete();
        mActive = 1'b0;
        mCur    = '0;
        mRemain = 0;
      end else begin
        if (mActive) begin
          mRemain--;
          if (mRemain == 0) mActive = 1'b0;
        end
        if (!mActive && mq.size() > 0) begin
          mCur    = mq.pop_front();
          mActive = 1'b1;
          mRemain = holdCycles(mCur);
        end
        if (!mActive) mCur = '0;
        if (cmd_valid && couldAccept) begin
          if (DROP_INVALID && refIllegal(cmd_data)) begin
            if (mDrop < 255) mDrop++;
          end else begin
            mq.push_back(cmd_data);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the rising edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'((rst === 1'b1) && (mq.size() < DEPTH) && !flush));
      checkOutput("issue_valid", 32'(issue_valid), 32'(mActive));
      checkOutput("pins", 32'({opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
                               direction, serial_in}), 32'(mCur[19:4]));
      checkOutput("res_valid", 32'(res_valid), 32'(mRes));
      checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrop));
      if (int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
    end
  end

  // Drive one cycle of inputs; they are sampled by the next rising edge.
  task automatic applyStimulus(input bit v, input logic [19:0] d, input bit fl, input bit r);
    cmd_valid = v;
    cmd_data  = d;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #2;
  endtask

  // Hold a command until it is accepted, bounded by a cycle budget.
  task automatic pushCmd(input logic [19:0] d);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      waited++;
      if (waited > 200) begin
        checkOutput("push_timeout", 32'(cmd_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [19:0] randCmd();
    logic [3:0] rep;
    rep = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
    return mkCmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
                 (($urandom_range(0, 3) == 0) ? 7'($urandom) : (7'($urandom) & 7'b1001111)), rep);
  endfunction

  initial begin : main
    int shiftCycles;
    int xorCycles;

    // Reset held for two edges with a command offered.
    rst = 1'b0; flush = 1'b0; cmd_valid = 1'b1;
    cmd_data = mkCmd(3'd2, 3'd1, 3'd1, 7'b0, 4'd0);
    @(posedge clk); #2;
    checkEn = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1; cmd_valid = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #2;

    // Three back-to-back ADDs: issued on consecutive cycles, results LAT later.
    applyStimulus(1'b1, mkCmd(3'd2, 3'd2, 3'd1, 7'b1000000, 4'd0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkCmd(3'd2, 3'd3, 3'd7, 7'b0000000, 4'd0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkCmd(3'd2, 3'd1, 3'd1, 7'b0000000, 4'd0), 1'b0, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("add2_issue", 32'(issue_valid), 32'd1);
    checkOutput("add2_A", 32'(A), 32'd3);
    checkOutput("add2_res_not_yet", 32'(res_valid), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("add3_A", 32'(A), 32'd1);
    checkOutput("add1_res", 32'(res_valid), 32'd1);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("idle_issue", 32'(issue_valid), 32'd0);
    checkOutput("idle_opcode", 32'(opcode), 32'd0);
    idleCycles(4);

    // SHIFT rep=3 holds the pins for four cycles, then the following XOR.
    pushCmd(mkCmd(3'd4, 3'd5, 3'd2, 7'b0000011, 4'd3));
    pushCmd(mkCmd(3'd1, 3'd6, 3'd3, 7'b0000000, 4'd9));
    shiftCycles = 0;
    xorCycles   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (issue_valid && opcode == 3'd4 && direction && serial_in) shiftCycles++;
      if (issue_valid && opcode == 3'd1) xorCycles++;
    end
    checkOutput("shift_hold_cycles", 32'(shiftCycles), 32'd4);
    checkOutput("xor_after_shift", 32'(xorCycles), 32'd1);
    @(posedge clk); #2;

    // Illegal commands are dropped and counted; legal ones still issue.
    pushCmd(mkCmd(3'd6, 3'd1, 3'd1, 7'b0, 4'd0));
    pushCmd(mkCmd(3'd0, 3'd3, 3'd0, 7'b0100000, 4'd0));
    idleCycles(3);
    @(negedge clk);
    checkOutput("drop_one", 32'(drop_cnt), 32'd1);
    @(posedge clk); #2;
    pushCmd(mkCmd(3'd2, 3'd1, 3'd1, 7'b0010000, 4'd0));
    @(negedge clk);
    checkOutput("drop_two", 32'(drop_cnt), 32'd2);
    idleCycles(4);

    // Fill behind a long repeat: ready falls at DEPTH, the extra one waits.
    maxCount = 0;
    pushCmd(mkCmd(3'd5, 3'd1, 3'd2, 7'b0000100, 4'd15));
    for (int i = 0; i < DEPTH; i++) pushCmd(mkCmd(3'd1, 3'(i), 3'(i + 1), 7'b0, 4'd0));
    @(negedge clk);
    checkOutput("full_count", 32'(fifo_count), 32'(DEPTH));
    checkOutput("full_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #2;
    pushCmd(mkCmd(3'd3, 3'd7, 3'd7, 7'b0, 4'd0));
    idleCycles(20);
    checkOutput("max_fill", 32'(maxCount), 32'(DEPTH));

    // Flush in the middle of a repeat with five commands queued.
    pushCmd(mkCmd(3'd4, 3'd2, 3'd1, 7'b0000010, 4'd15));
    for (int i = 0; i < 5; i++) pushCmd(mkCmd(3'd2, 3'(i), 3'd1, 7'b0, 4'd0));
    idleCycles(1);
    applyStimulus(1'b1, mkCmd(3'd0, 3'd1, 3'd1, 7'b0, 4'd0), 1'b1, 1'b1);
    cmd_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    checkOutput("flush_count", 32'(fifo_count), 32'd0);
    checkOutput("flush_issue", 32'(issue_valid), 32'd0);
    checkOutput("flush_pins", 32'({opcode, A, B, direction, serial_in}), 32'd0);
    checkOutput("flush_res_inflight0", 32'(res_valid), 32'd1);
    @(negedge clk);
    checkOutput("flush_res_inflight1", 32'(res_valid), 32'd1);
    @(negedge clk);
    checkOutput("flush_res_done", 32'(res_valid), 32'd0);
    @(posedge clk); #2;

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 99) < 60, randCmd(), $urandom_range(0, 99) < 3,
                    $urandom_range(0, 199) != 0);
    end
    idleCycles(40);

    // Drop counter saturates at 255.
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, mkCmd(3'd7, 3'd0, 3'd0, 7'b0, 4'd0), 1'b0, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("drop_saturate", 32'(drop_cnt), 32'd255);
    @(posedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
